// File: rtl/inst_mem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
package inst_mem_loader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } loader_state_e;

  localparam int unsigned BYTE_W         = 8;
  localparam int unsigned BYTES_PER_INST = 4;
  localparam int unsigned BYTE_IDX_W     = 2;
  localparam int unsigned WORD_W         = BYTE_W * BYTES_PER_INST;

  // addi x0, x0, 0
  localparam logic [31:0] RV_NOP_INST = 32'h0000_0013;

endpackage

// File: rtl/inst_mem_loader_byte_packer.sv
// Little-endian byte-lane packer: inserts each pushed byte at the next lane of a word.
module inst_mem_loader_byte_packer
  import inst_mem_loader_pkg::*;
(
  input  logic              clock,
  input  logic              reset_n,
  input  logic              clear,
  input  logic              push,
  input  logic [BYTE_W-1:0] push_data,
  output logic [WORD_W-1:0] word,
  output logic              full_c
);

  logic [BYTE_IDX_W-1:0] byte_idx;

  // High on the push that fills the top lane; the index wraps back to 0 with it.
  assign full_c = push && (byte_idx == BYTE_IDX_W'(BYTES_PER_INST - 1));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      word     <= '0;
      byte_idx <= '0;
    end else if (clear) begin
      word     <= '0;
      byte_idx <= '0;
    end else if (push) begin
      byte_idx <= byte_idx + BYTE_IDX_W'(1);
      for (int unsigned i = 0; i < BYTES_PER_INST; i++) begin
        if (byte_idx == BYTE_IDX_W'(i)) begin
          word[BYTE_W*i +: BYTE_W] <= push_data;
        end
      end
    end
  end

endmodule

// File: rtl/inst_mem_loader.sv
// Loads a byte stream into the instruction memory as packed words and arbitrates
// the single memory port between the loader and the CPU fetch path.
module inst_mem_loader
  import inst_mem_loader_pkg::*;
#(
  parameter int unsigned    XLEN      = 32,
  parameter int unsigned    ILEN      = 32,
  parameter int unsigned    MEM_SIZE  = 1024,
  parameter int unsigned    BASE_ADDR = 0,
  parameter logic [ILEN-1:0] NOP_INST = ILEN'(RV_NOP_INST)
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            start,
  input  logic [XLEN-1:0] length,
  input  logic [7:0]      byte_data,
  input  logic            byte_valid,
  output logic            byte_ready,
  input  logic [XLEN-1:0] fetch_pc,
  output logic [ILEN-1:0] fetch_inst,
  output logic            fetch_stall,
  output logic [XLEN-1:0] mem_pc,
  output logic [ILEN-1:0] mem_wdata,
  output logic            mem_write_en,
  input  logic [ILEN-1:0] mem_inst,
  output logic            busy,
  output logic            done,
  output logic            error
);

  loader_state_e   state_q;
  logic [XLEN-1:0] remaining_q;
  logic [XLEN-1:0] wr_addr_q;
  logic [WORD_W-1:0] packed_word;

  logic            accept_c;
  logic            clear_c;
  logic            full_c;
  logic            last_byte_c;
  logic            oob_c;
  logic [XLEN:0]   end_addr_c;

  assign accept_c    = byte_valid && byte_ready;
  assign clear_c     = (state_q != ST_LOAD);
  assign last_byte_c = (remaining_q == XLEN'(1));

  // One extra bit so a huge length cannot wrap past the bound unnoticed.
  assign end_addr_c = {1'b0, length} + (XLEN+1)'(BASE_ADDR);
  assign oob_c      = end_addr_c > (XLEN+1)'(MEM_SIZE);

  inst_mem_loader_byte_packer u_packer (
    .clock     (clock),
    .reset_n   (reset_n),
    .clear     (clear_c),
    .push      (accept_c),
    .push_data (byte_data),
    .word      (packed_word),
    .full_c    (full_c)
  );

  // Sequencer: state plus registered handshake/status outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      remaining_q  <= '0;
      wr_addr_q    <= '0;
      byte_ready   <= 1'b0;
      mem_write_en <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
    end else begin
      done  <= 1'b0;
      error <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            if (length == '0) begin
              state_q <= ST_DONE;
              busy    <= 1'b1;
              done    <= 1'b1;
            end else if (oob_c) begin
              error <= 1'b1;
            end else begin
              state_q     <= ST_LOAD;
              remaining_q <= length;
              wr_addr_q   <= XLEN'(BASE_ADDR);
              busy        <= 1'b1;
              byte_ready  <= 1'b1;
            end
          end
        end
        ST_LOAD: begin
          if (accept_c) begin
            remaining_q <= remaining_q - XLEN'(1);
            if (full_c || last_byte_c) begin
              state_q      <= ST_WRITE;
              byte_ready   <= 1'b0;
              mem_write_en <= 1'b1;
            end
          end
        end
        ST_WRITE: begin
          mem_write_en <= 1'b0;
          wr_addr_q    <= wr_addr_q + XLEN'(BYTES_PER_INST);
          if (remaining_q != '0) begin
            state_q    <= ST_LOAD;
            byte_ready <= 1'b1;
          end else begin
            state_q <= ST_DONE;
            done    <= 1'b1;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          busy    <= 1'b0;
        end
        default: begin
          state_q      <= ST_IDLE;
          byte_ready   <= 1'b0;
          mem_write_en <= 1'b0;
          busy         <= 1'b0;
        end
      endcase
    end
  end

  // Port arbitration: the loader owns the memory port whenever busy.
  assign mem_pc      = busy ? wr_addr_q : fetch_pc;
  assign fetch_inst  = busy ? NOP_INST : mem_inst;
  assign fetch_stall = busy;
  assign mem_wdata   = ILEN'(packed_word);

endmodule

// File: tb/tb_inst_mem_loader.sv
// Scoreboard bench for inst_mem_loader with a behavioural instruction memory.
module tb_inst_mem_loader;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        start;
  logic [31:0] length;
  logic [7:0]  byte_data;
  logic        byte_valid;
  logic        byte_ready;
  logic [31:0] fetch_pc;
  logic [31:0] fetch_inst;
  logic        fetch_stall;
  logic [31:0] mem_pc;
  logic [31:0] mem_wdata;
  logic        mem_write_en;
  logic [31:0] mem_inst;
  logic        busy;
  logic        done;
  logic        error;

  inst_mem_loader dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .start        (start),
    .length       (length),
    .byte_data    (byte_data),
    .byte_valid   (byte_valid),
    .byte_ready   (byte_ready),
    .fetch_pc     (fetch_pc),
    .fetch_inst   (fetch_inst),
    .fetch_stall  (fetch_stall),
    .mem_pc       (mem_pc),
    .mem_wdata    (mem_wdata),
    .mem_write_en (mem_write_en),
    .mem_inst     (mem_inst),
    .busy         (busy),
    .done         (done),
    .error        (error)
  );

  always #5 clock = ~clock;

  // Behavioural instruction memory: combinational read, clocked write.
  logic [31:0] mem [0:255];
  assign mem_inst = mem[mem_pc[9:2]];
  always @(posedge clock) if (mem_write_en) mem[mem_pc[9:2]] <= mem_wdata;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t  sb_q[$];
  wr_t  mon_e;
  int   we_log[$];
  int   done_log[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   t0       = 0;
  int   n_wr     = 0;
  int   n_done   = 0;
  int   n_err    = 0;
  int   stall_cnt = 0;
  int   arb_bad  = 0;
  int   rdy_bad  = 0;
  logic [7:0] img [0:15];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(posedge clock) cyc <= cyc + 1;

  // Monitor: scoreboard pops on each write, plus event logs and arbitration tally.
  always @(negedge clock) begin
    if (reset_n) begin
      if (fetch_stall !== busy) arb_bad++;
      if (busy && fetch_inst !== NOP) arb_bad++;
      if (!busy && (fetch_inst !== mem_inst || mem_pc !== fetch_pc)) arb_bad++;
      if (fetch_stall) stall_cnt++;
      if (done) begin
        n_done++;
        done_log.push_back(cyc - t0);
      end
      if (error) n_err++;
      if (mem_write_en) begin
        n_wr++;
        we_log.push_back(cyc - t0);
        if (byte_ready) rdy_bad++;
        if (sb_q.size() == 0) begin
          check("wr_unexpected", 64'(mem_pc), 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          mon_e = sb_q.pop_front();
          check("wr_addr", 64'(mem_pc), 64'(mon_e.addr));
          check("wr_data", 64'(mem_wdata), 64'(mon_e.data));
        end
      end
    end
  end

  function automatic logic [31:0] exp_word(input int w, input int len);
    logic [31:0] d;
    d = '0;
    for (int j = 0; j < 4; j++) if (4*w + j < len) d[8*j +: 8] = img[4*w + j];
    return d;
  endfunction

  // Stream n bytes from img, optionally toggling valid and re-pulsing start once.
  task automatic stream(input int n, input bit gaps, input int dup_at);
    int  idx = 0;
    int  guard = 0;
    bit  tog = 1'b0;
    bit  dup_sent = 1'b0;
    logic rdy;
    while (idx < n && guard < 200) begin
      tog        = !tog;
      byte_valid = gaps ? tog : 1'b1;
      byte_data  = img[idx];
      if (idx == dup_at && !dup_sent) begin
        start    = 1'b1;
        length   = 32'd4;
        dup_sent = 1'b1;
      end else begin
        start = 1'b0;
      end
      rdy = byte_ready;
      @(posedge clock);
      if (rdy && byte_valid) idx++;
      @(negedge clock);
      guard++;
    end
    byte_valid = 1'b0;
    start      = 1'b0;
    if (guard >= 200) check("stream_timeout", 64'(idx), 64'(n));
  endtask

  task automatic do_load(input int len, input int nsend, input bit gaps, input int dup_at);
    for (int w = 0; w < (len + 3) / 4; w++) sb_q.push_back('{addr: 32'(4*w), data: exp_word(w, len)});
    we_log.delete();
    done_log.delete();
    @(negedge clock);
    start  = 1'b1;
    length = 32'(len);
    t0     = cyc;
    @(posedge clock);
    @(negedge clock);
    start = 1'b0;
    stream(nsend, gaps, dup_at);
  endtask

  task automatic wait_idle();
    int g = 0;
    while (busy && g < 50) begin
      @(negedge clock);
      g++;
    end
    check("idle_after_load", 64'(busy), 64'(0));
  endtask

  int wr0, dn0;
  logic [31:0] w0;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;
    mem[2]     = 32'hDEAD_BEEF;
    reset_n    = 1'b0;
    start      = 1'b0;
    length     = '0;
    byte_data  = '0;
    byte_valid = 1'b0;
    fetch_pc   = 32'd8;

    // Reset state and idle pass-through
    repeat (2) @(negedge clock);
    check("rst_byte_ready", 64'(byte_ready), 64'(0));
    check("rst_write_en", 64'(mem_write_en), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_error", 64'(error), 64'(0));
    check("rst_stall", 64'(fetch_stall), 64'(0));
    reset_n = 1'b1;
    @(negedge clock);
    check("idle_mem_pc", 64'(mem_pc), 64'd8);
    check("idle_fetch_inst", 64'(fetch_inst), 64'hDEAD_BEEF);
    check("idle_stall", 64'(fetch_stall), 64'(0));

    // Full-word load, back-to-back bytes
    img[0] = 8'h13; img[1] = 8'h05; img[2] = 8'hA0; img[3] = 8'h00;
    img[4] = 8'h93; img[5] = 8'h05; img[6] = 8'hB0; img[7] = 8'h00;
    stall_cnt = 0;
    do_load(8, 8, 1'b0, -1);
    wait_idle();
    check("full_we_count", 64'(we_log.size()), 64'd2);
    check("full_we_cycle0", 64'(we_log[0]), 64'd5);
    check("full_we_cycle1", 64'(we_log[1]), 64'd10);
    check("full_done_count", 64'(done_log.size()), 64'd1);
    check("full_done_cycle", 64'(done_log[0]), 64'd11);
    check("full_stall_cycles", 64'(stall_cnt), 64'd11);
    check("full_mem0", 64'(mem[0]), 64'h00A0_0513);
    check("full_mem1", 64'(mem[1]), 64'h00B0_0593);

    // Partial last word with gaps in byte_valid
    for (int i = 0; i < 6; i++) img[i] = 8'($urandom_range(1, 255));
    wr0 = n_wr;
    dn0 = n_done;
    do_load(6, 6, 1'b1, -1);
    wait_idle();
    check("part_writes", 64'(n_wr - wr0), 64'd2);
    check("part_done", 64'(n_done - dn0), 64'd1);
    check("part_mem1", 64'(mem[1]), 64'({16'h0, img[5], img[4]}));
    check("part_rdy_in_write", 64'(rdy_bad), 64'd0);

    // Out-of-bounds length is rejected
    wr0 = n_wr;
    @(negedge clock);
    start  = 1'b1;
    length = 32'd1025;
    @(posedge clock);
    @(negedge clock);
    start = 1'b0;
    check("oob_error", 64'(error), 64'd1);
    check("oob_busy", 64'(busy), 64'd0);
    @(negedge clock);
    check("oob_error_pulse", 64'(error), 64'd0);
    check("oob_no_write", 64'(n_wr - wr0), 64'd0);

    // Zero length completes immediately
    @(negedge clock);
    start  = 1'b1;
    length = 32'd0;
    @(posedge clock);
    @(negedge clock);
    start = 1'b0;
    check("zero_done", 64'(done), 64'd1);
    check("zero_busy", 64'(busy), 64'd1);
    @(negedge clock);
    check("zero_done_pulse", 64'(done), 64'd0);
    check("zero_idle", 64'(busy), 64'd0);
    check("zero_no_write", 64'(n_wr - wr0), 64'd0);
    check("err_total", 64'(n_err), 64'd1);

    // Start pulse while busy is ignored
    for (int i = 0; i < 8; i++) img[i] = 8'($urandom_range(0, 255));
    wr0 = n_wr;
    dn0 = n_done;
    do_load(8, 8, 1'b0, 2);
    wait_idle();
    check("dup_writes", 64'(n_wr - wr0), 64'd2);
    check("dup_done", 64'(n_done - dn0), 64'd1);
    check("dup_sb_empty", 64'(sb_q.size()), 64'd0);
    check("dup_mem1", 64'(mem[1]), 64'(exp_word(1, 8)));

    // Reset mid-load after 6 of 8 bytes
    for (int i = 0; i < 8; i++) img[i] = 8'($urandom_range(0, 255));
    img[0] = ~mem[0][7:0];
    w0  = exp_word(0, 8);
    dn0 = n_done;
    do_load(8, 6, 1'b0, -1);
    reset_n = 1'b0;
    #1;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_byte_ready", 64'(byte_ready), 64'd0);
    check("abort_stall", 64'(fetch_stall), 64'd0);
    check("abort_write_en", 64'(mem_write_en), 64'd0);
    check("abort_mem0", 64'(mem[0]), 64'(w0));
    check("abort_pending", 64'(sb_q.size()), 64'd1);
    sb_q.delete();
    repeat (2) @(negedge clock);
    reset_n  = 1'b1;
    fetch_pc = 32'd0;
    @(negedge clock);
    check("abort_no_done", 64'(n_done - dn0), 64'd0);
    check("post_fetch_inst", 64'(fetch_inst), 64'(w0));
    check("post_stall", 64'(fetch_stall), 64'd0);
    fetch_pc = 32'd8;
    @(negedge clock);
    check("post_fetch_8", 64'(fetch_inst), 64'hDEAD_BEEF);
    check("arbitration", 64'(arb_bad), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/inst_mem_loader.md
Name: inst_mem_loader

Overview:
- Sequencer and port arbiter for the single-ported byte-addressed instruction memory.
- Accepts a byte stream over a valid/ready handshake and packs it little-endian into ILEN-bit words, one write cycle per word from BASE_ADDR upward.
- While loading, it owns the memory address/write port and stalls the fetch side. When idle, the fetch PC passes straight through.

Parameters:
- XLEN, 32, address/PC width.
- ILEN, 32, instruction word width; fixed at 32 (4 bytes per word).
- MEM_SIZE, 1024, memory size in bytes; used for bounds check.
- BASE_ADDR, 0, byte address of first loaded word; must be 4-byte aligned.
- NOP_INST, 32'h0000_0013, instruction driven to fetch while stalled.

Ports:
- clock  in  1  rising-edge clock.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle load request; sampled only in IDLE.
- length  in  XLEN  byte count of image; sampled with start.
- byte_data  in  8  stream byte.
- byte_valid  in  1  stream byte valid.
- byte_ready  out  1  loader accepts byte this cycle.
- fetch_pc  in  XLEN  CPU fetch address.
- fetch_inst  out  ILEN  instruction returned to CPU.
- fetch_stall  out  1  CPU must hold PC.
- mem_pc  out  XLEN  memory address port.
- mem_wdata  out  ILEN  memory write data.
- mem_write_en  out  1  memory write strobe.
- mem_inst  in  ILEN  memory combinational read data.
- busy  out  1  load in progress.
- done  out  1  one-cycle pulse: load completed.
- error  out  1  one-cycle pulse: load rejected (out of bounds).

Behaviour:
- Reset (async, reset_n=0):
  - State=IDLE; all counters and the word buffer cleared.
  - byte_ready=0, mem_write_en=0, busy=0, done=0, error=0, fetch_stall=0.
- States: IDLE, LOAD, WRITE, DONE.
- IDLE:
  - start=1 with length=0 -> DONE; no writes.
  - start=1 with BASE_ADDR+length > MEM_SIZE -> error pulses next cycle; stay IDLE; no writes.
  - Otherwise latch remaining=length, wr_addr=BASE_ADDR, byte_idx=0, word buffer=0 -> LOAD.
  - start while not in IDLE is ignored.
- LOAD:
  - byte_ready=1.
  - On byte_valid&&byte_ready: buffer[8*byte_idx +: 8]=byte_data; byte_idx++; remaining--.
  - -> WRITE when byte_idx wraps 3->0, or when remaining reaches 0.
  - On a partial last word, unreceived bytes stay 0 (zero padding).
- WRITE (exactly 1 cycle):
  - byte_ready=0, mem_write_en=1, mem_pc=wr_addr, mem_wdata=buffer.
  - Then wr_addr+=4, buffer cleared, byte_idx=0.
  - -> LOAD if remaining!=0, else DONE.
- DONE (1 cycle): done=1 -> IDLE.
- busy=1 in LOAD, WRITE, DONE.
- Arbitration (combinational):
  - busy=0: mem_pc=fetch_pc, fetch_inst=mem_inst, fetch_stall=0, mem_write_en=0.
  - busy=1: mem_pc=wr_addr, fetch_inst=NOP_INST, fetch_stall=1.
- Throughput: with byte_valid held high, each full word takes 4 LOAD cycles + 1 WRITE cycle. A 4N-byte image completes in 5N cycles, then 1 DONE cycle.
- Gaps in byte_valid stall LOAD with no timeout; the buffer is held.
- Address arithmetic is XLEN-bit unsigned. The bounds check forbids wrap-around, so wr_addr never exceeds MEM_SIZE-4.
- reset_n asserted mid-load aborts immediately:
  - Words already written remain in memory.
  - The partial buffer is discarded and no done pulse is issued.

Decomposition:
- Shared package (rvsv_pkg or existing equivalent) holds:
  - the state enum typedef (IDLE/LOAD/WRITE/DONE);
  - the NOP_INST constant (32'h0000_0013, addi x0,x0,0);
  - BYTES_PER_INST=4.
- One natural sub-module: byte_packer — byte-lane shift/insert buffer with byte_idx counter, clear and full outputs. The FSM, bounds check and port mux stay in inst_mem_loader.
- The bench instantiates inst_mem_loader alongside the existing instruction memory.

Test Plan:
- Reset, idle fetch: reset_n low then high, fetch_pc=8 -> mem_pc=8, fetch_inst=mem_inst, fetch_stall=0, busy=0.
- Full-word load: start, length=8, bytes 13 05 A0 00 93 05 B0 00 streamed back-to-back -> mem[0..3]=32'h00A00513 and mem[4..7]=32'h00B00593; mem_write_en high exactly on cycles 5 and 10; done on cycle 11; fetch_stall high throughout.
- Partial word with gaps: length=6, byte_valid toggled every other cycle -> second word written as 32'h0000_xxyy (upper bytes zero); byte_ready low during WRITE; done pulses once.
- Bounds/zero length:
  - length=MEM_SIZE-BASE_ADDR+1 -> error pulse, no mem_write_en, busy stays 0.
  - length=0 -> done pulse next cycle, no writes.
- Start ignored while busy: second start pulse mid-LOAD -> no effect on remaining count or address sequence.
- Reset mid-load: assert reset_n after 6 of 8 bytes -> outputs immediately at reset values; first word remains in memory; no done pulse; a subsequent fetch works normally.
